// File: rtl/dff_dut_pkg.sv
// Shared constants, data type and parity helper for the DFF register slice.
package dff_pkg;

    localparam int unsigned DFF_WIDTH = 4;

    typedef logic [DFF_WIDTH-1:0] dff_data_t;

    localparam dff_data_t DFF_RESET_VALUE = 4'h0;

    // Even parity; zero-extension to 64 bits leaves the parity unchanged.
    function automatic logic parity_f(input logic [63:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/dff_dut_if.sv
// Bus interface between the DFF environment and dff_dut (parity pin with DFF_DUT_PARITY_EN).
interface dff_intf
    import dff_pkg::*;
#(
    parameter int unsigned WIDTH = DFF_WIDTH
) ();

    logic             top_rst;
    logic [WIDTH-1:0] top_d;
    logic [WIDTH-1:0] top_q;
`ifdef DFF_DUT_PARITY_EN
    logic             top_q_par;
`endif

`ifdef DFF_DUT_PARITY_EN
    modport master (output top_rst, output top_d, input top_q, input top_q_par);
    modport slave  (input top_d, output top_q, output top_q_par);
`else
    modport master (output top_rst, output top_d, input top_q);
    modport slave  (input top_d, output top_q);
`endif

endinterface

// File: rtl/dff_dut_stage.sv
// One WIDTH-bit register stage with synchronous active-high reset.
module dff_stage
    import dff_pkg::*;
#(
    parameter int unsigned          WIDTH       = DFF_WIDTH,
    parameter logic [WIDTH-1:0]     RESET_VALUE = WIDTH'(DFF_RESET_VALUE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_dut.sv
// STAGES-deep synchronously reset register chain from bus.top_d to bus.top_q.
// Optional even-parity output bus.top_q_par enabled by macro DFF_DUT_PARITY_EN.
module dff_dut
    import dff_pkg::*;
#(
    parameter int unsigned      WIDTH       = DFF_WIDTH,
    parameter int unsigned      STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DFF_RESET_VALUE)
) (
    input  logic    clk,
    input  logic    rst,
    dff_intf.slave  bus
);

    localparam int unsigned CNT_W = $clog2(STAGES + 1);

    if (WIDTH < 1) begin : g_bad_width
        $error("dff_dut: WIDTH must be >= 1");
    end
    if (STAGES < 1) begin : g_bad_stages
        $error("dff_dut: STAGES must be >= 1");
    end

    logic [WIDTH-1:0] stage_d [STAGES];
    logic [WIDTH-1:0] stage_q [STAGES];

    assign stage_d[0] = bus.top_d;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k > 0) begin : g_link
            assign stage_d[k] = stage_q[k-1];
        end
        dff_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .d   (stage_d[k]),
            .q   (stage_q[k])
        );
    end

    assign bus.top_q = stage_q[STAGES-1];

`ifdef DFF_DUT_PARITY_EN
    if (WIDTH > 64) begin : g_bad_par_width
        $error("dff_dut: parity output supports WIDTH <= 64");
    end

    // Parity taken from the last stage's input so it lands with Q on the same edge.
    logic q_par_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_par_r <= parity_f(64'(RESET_VALUE));
        end else begin
            q_par_r <= parity_f(64'(stage_d[STAGES-1]));
        end
    end

    assign bus.top_q_par = q_par_r;
`endif

    // Edges since the last reset, saturating at STAGES; gates the latency check.
    logic [CNT_W-1:0] since_rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            since_rst <= '0;
        end else if (since_rst < CNT_W'(STAGES)) begin
            since_rst <= since_rst + CNT_W'(1);
        end
    end

    a_reset_value: assert property (@(posedge clk) rst |=> (bus.top_q == RESET_VALUE));

    a_latency: assert property (@(posedge clk)
        (since_rst == CNT_W'(STAGES)) |-> (bus.top_q == $past(bus.top_d, STAGES)));

endmodule

// File: tb/tb_dff_dut.sv
// Directed bench for dff_dut: 1-stage and 3-stage instances, table vectors plus mid-cycle sequences.
module tb_dff_dut;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dff_intf #(.WIDTH(4)) bus1 ();
    dff_intf #(.WIDTH(4)) bus3 ();

    assign bus1.top_rst = rst;
    assign bus1.top_d   = d;
    assign bus3.top_rst = rst;
    assign bus3.top_d   = d;

    dff_dut #(.WIDTH(4), .STAGES(1), .RESET_VALUE(4'h0)) u_dut1 (
        .clk (clk),
        .rst (bus1.top_rst),
        .bus (bus1)
    );

    dff_dut #(.WIDTH(4), .STAGES(3), .RESET_VALUE(4'h0)) u_dut3 (
        .clk (clk),
        .rst (bus3.top_rst),
        .bus (bus3)
    );

    typedef struct {
        logic       rst;
        logic [3:0] d;
        logic [3:0] q1;
        logic [3:0] q3;
    } vec_t;

    vec_t vecs [15];

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // q3 after edge i = d from edge i-2 unless rst was high on any of edges i-2..i.
        vecs[0]  = '{1'b1, 4'hF, 4'h0, 4'h0};
        vecs[1]  = '{1'b1, 4'hF, 4'h0, 4'h0};
        vecs[2]  = '{1'b0, 4'hA, 4'hA, 4'h0};
        vecs[3]  = '{1'b0, 4'h3, 4'h3, 4'h0};
        vecs[4]  = '{1'b0, 4'h5, 4'h5, 4'hA};
        vecs[5]  = '{1'b1, 4'h5, 4'h0, 4'h0};
        vecs[6]  = '{1'b1, 4'h7, 4'h0, 4'h0};
        vecs[7]  = '{1'b0, 4'h7, 4'h7, 4'h0};
        vecs[8]  = '{1'b0, 4'h0, 4'h0, 4'h0};
        vecs[9]  = '{1'b0, 4'hF, 4'hF, 4'h7};
        vecs[10] = '{1'b0, 4'h2, 4'h2, 4'h0};
        vecs[11] = '{1'b0, 4'h9, 4'h9, 4'hF};
        vecs[12] = '{1'b0, 4'hB, 4'hB, 4'h2};
        vecs[13] = '{1'b0, 4'h1, 4'h1, 4'h9};
        vecs[14] = '{1'b0, 4'h1, 4'h1, 4'hB};

        rst = 1'b1;
        d   = 4'hF;
        #2;

        for (int i = 0; i < 15; i++) begin
            rst = vecs[i].rst;
            d   = vecs[i].d;
            tick();
            check4($sformatf("vec%0d_q1", i), bus1.top_q, vecs[i].q1);
            check4($sformatf("vec%0d_q3", i), bus3.top_q, vecs[i].q3);
`ifdef DFF_DUT_PARITY_EN
            check1($sformatf("vec%0d_par1", i), bus1.top_q_par, ^vecs[i].q1);
            check1($sformatf("vec%0d_par3", i), bus3.top_q_par, ^vecs[i].q3);
`endif
        end

        // Reset asserted mid-cycle: Q holds until the next edge.
        rst = 1'b0;
        d   = 4'h5;
        tick();
        check4("sync_pre", bus1.top_q, 4'h5);
        #2;
        rst = 1'b1;
        #1;
        check4("sync_assert_hold", bus1.top_q, 4'h5);
        tick();
        check4("sync_assert_edge", bus1.top_q, 4'h0);

        // Reset released mid-cycle: Q holds reset value until the next edge.
        #2;
        rst = 1'b0;
        #1;
        check4("sync_release_hold", bus1.top_q, 4'h0);
        tick();
        check4("sync_release_edge", bus1.top_q, 4'h5);

        // D glitches between edges are invisible; only the value at the edge lands.
        d = 4'h6;
        tick();
        check4("glitch_pre", bus1.top_q, 4'h6);
        d = 4'h1;
        #1;
        check4("glitch_d1", bus1.top_q, 4'h6);
        d = 4'h9;
        #1;
        check4("glitch_d9", bus1.top_q, 4'h6);
        d = 4'hC;
        #1;
        check4("glitch_dC", bus1.top_q, 4'h6);
        tick();
        check4("glitch_edge", bus1.top_q, 4'hC);

        // Reset mid-stream flushes the 3-stage pipe; no stale data after release.
        d = 4'hE;
        tick();
        rst = 1'b1;
        tick();
        check4("flush_q3_reset", bus3.top_q, 4'h0);
        rst = 1'b0;
        d   = 4'hB;
        tick();
        check4("flush_q3_n", bus3.top_q, 4'h0);
        d = 4'h4;
        tick();
        check4("flush_q3_n1", bus3.top_q, 4'h0);
        tick();
        check4("flush_q3_n2", bus3.top_q, 4'hB);
`ifdef DFF_DUT_PARITY_EN
        check1("flush_par3_n2", bus3.top_q_par, 1'b1);
`endif
        tick();
        check4("flush_q3_n3", bus3.top_q, 4'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
